// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive/transmit blocks.
//   rx_state_e : receiver FSM states
//   LINE_IDLE  : idle/stop level for a 2-flop line synchronizer (both flops high)
//   DATA_W     : payload width of one UART character
package uart_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic [1:0] LINE_IDLE = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_receiver_if.sv
// uart_receiver_if: received-byte handshake plus line status.
//   data_out       : received byte, stable while data_out_valid is high
//   data_out_valid : byte available
//   data_out_ready : consumer accepts (transfer on valid && ready)
//   framing_error  : one-cycle pulse, stop bit sampled low
//   overrun        : sticky, a good frame was dropped; cleared by a transfer
// master = receiver side, slave = consumer side.
interface uart_receiver_if;

  logic [uart_pkg::DATA_W-1:0] data_out;
  logic                        data_out_valid;
  logic                        data_out_ready;
  logic                        framing_error;
  logic                        overrun;

  modport master (
    output data_out,
    output data_out_valid,
    input  data_out_ready,
    output framing_error,
    output overrun
  );

  modport slave (
    input  data_out,
    input  data_out_valid,
    output data_out_ready,
    input  framing_error,
    input  overrun
  );

endinterface

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for an asynchronous single-bit input.
//   clk, rst : core clock, async active-high reset
//   d_i      : asynchronous input
//   q_o      : synchronized output (second flop)
// RESET_VAL sets both flops on reset so a line reads as idle out of reset.
module sync2
  import uart_pkg::*;
#(
  parameter logic [1:0] RESET_VAL = LINE_IDLE
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receive front end with a one-byte ready/valid buffer.
//   clk       : core clock
//   rst       : async active-high reset
//   serial_in : asynchronous UART line, idle high
//   rx        : uart_receiver_if.master (data_out, data_out_valid,
//               data_out_ready, framing_error, overrun)
// Bits are sampled mid-period: the counter is re-phased at the start-bit
// midpoint, so every later wrap of the full bit period lands mid-bit.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 125_000_000,
  parameter int unsigned BAUD_RATE  = 115_200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  uart_receiver_if.master  rx
);

  localparam int unsigned SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int unsigned CNT_W            = $clog2(SYMBOL_EDGE_TIME);

  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_TIME - 1);
  localparam logic [CNT_W-1:0] CNT_SYMBOL = CNT_W'(SYMBOL_EDGE_TIME - 1);

  logic rx_s;

  rx_state_e         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        idx_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              framing_error_q;
  logic              overrun_q;
  logic              xfer_c;

  sync2 #(
    .RESET_VAL (LINE_IDLE)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (serial_in),
    .q_o (rx_s)
  );

  assign xfer_c = valid_q && rx.data_out_ready;

  // Frame FSM, bit counter, shift register and output buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      idx_q           <= '0;
      shift_q         <= '0;
      data_q          <= '0;
      valid_q         <= 1'b0;
      framing_error_q <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      framing_error_q <= 1'b0;

      // A transfer empties the buffer; a delivery below may refill it.
      if (xfer_c) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end

        START: begin
          if (cnt_q == CNT_SAMPLE) begin
            cnt_q <= '0;
            idx_q <= '0;
            // Line back high at mid start bit: treat as a glitch.
            state_q <= rx_s ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        DATA: begin
          if (cnt_q == CNT_SYMBOL) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rx_s;
            if (idx_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        STOP: begin
          if (cnt_q == CNT_SYMBOL) begin
            cnt_q <= '0;
            if (rx_s) begin
              state_q <= IDLE;
              if (!valid_q || xfer_c) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              framing_error_q <= 1'b1;
              state_q         <= BREAK;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        BREAK: begin
          // Hold off until the line returns high so a stuck-low line
          // does not look like a stream of start bits.
          if (rx_s) begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rx.data_out       = data_q;
  assign rx.data_out_valid = valid_q;
  assign rx.framing_error  = framing_error_q;
  assign rx.overrun        = overrun_q;

endmodule
